// File: rtl/mdr_control_seq_if.sv
// rtl/mdr_control_seq_if.sv - load/control/status bus between the MDR user side and mdr_control_seq
//
// Purpose: groups every non-clock, non-reset signal of the MDR control
// sequencer into one bundle.
//   master modport : user side; drives start/load/data_in/stall/abort/result_ack
//   slave modport  : sequencer; drives busy, dp_clear, load strobes, op_code,
//                    dp_step, step_idx, last_step, ready, error, err_code
interface mdr_control_seq_if #(
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              start;
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              stall;
  logic              abort;
  logic              result_ack;

  logic              busy;
  logic              dp_clear;
  logic              load_x;
  logic              load_y;
  logic              load_op;
  logic [1:0]        op_code;
  logic              dp_step;
  logic [CNT_W-1:0]  step_idx;
  logic              last_step;
  logic              ready;
  logic              error;
  logic [1:0]        err_code;

  modport master (
    output start, load, data_in, stall, abort, result_ack,
    input  busy, dp_clear, load_x, load_y, load_op, op_code,
    input  dp_step, step_idx, last_step, ready, error, err_code
  );

  modport slave (
    input  start, load, data_in, stall, abort, result_ack,
    output busy, dp_clear, load_x, load_y, load_op, op_code,
    output dp_step, step_idx, last_step, ready, error, err_code
  );
endinterface

// File: rtl/mdr_control_seq.sv
// rtl/mdr_control_seq.sv - control sequencer for the iterative multiply/divide/sqrt unit
//
// Purpose: loads X, Y and opcode over a shared bus, rejects divide-by-zero
// and invalid opcodes, then issues one dp_step per non-stalled PROCESS cycle
// (N = DATA_W for MUL/DIV, DATA_W/2 for SQRT) and reports ready or a coded
// error held until result_ack.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - mdr_control_seq_if.slave (handshake inputs, strobes and status)
// Parameters: DATA_W (even, >= 4), TIMEOUT (stall cycles tolerated in PROCESS).
// Optional build macro: MDR_WATCHDOG_EN adds a consecutive-stall watchdog
// that aborts PROCESS with err_code 11 after TIMEOUT stalled cycles.
module mdr_control_seq #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  mdr_control_seq_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  if (DATA_W < 4 || (DATA_W % 2) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("mdr_control_seq: DATA_W must be even and >= 4, TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOADX,
    S_LOADY,
    S_LOADOP,
    S_PROCESS,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] step_idx;
  logic [1:0]       op_code;
  logic [1:0]       err_code;
  logic             y_zero;
  logic [CNT_W-1:0] last_idx;
  logic             wd_trip;

  // SQRT resolves two result bits per step, so it needs half the iterations.
  assign last_idx = (op_code == 2'b10) ? CNT_W'(DATA_W / 2 - 1) : CNT_W'(DATA_W - 1);

`ifdef MDR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] stall_cnt;

  // Trips on the TIMEOUT-th consecutive stalled PROCESS cycle.
  assign wd_trip = (state == S_PROCESS) && bus.stall && (stall_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != S_PROCESS || !bus.stall || bus.abort) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Without the watchdog PROCESS simply waits out any stall.
  assign wd_trip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      step_idx <= '0;
      op_code  <= 2'b00;
      err_code <= 2'b00;
      y_zero   <= 1'b0;
    end else if (bus.abort && state != S_IDLE) begin
      state    <= S_IDLE;
      step_idx <= '0;
      op_code  <= 2'b00;
      err_code <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) state <= S_SETUP;
        end
        S_SETUP: begin
          state <= S_LOADX;
        end
        S_LOADX: begin
          if (bus.load) state <= S_LOADY;
        end
        S_LOADY: begin
          if (bus.load) begin
            state  <= S_LOADOP;
            y_zero <= (bus.data_in == '0);
          end
        end
        S_LOADOP: begin
          if (bus.load) begin
            op_code <= bus.data_in[1:0];
            if (bus.data_in[1:0] == 2'b11) begin
              state    <= S_ERROR;
              err_code <= 2'b10;
            end else if (bus.data_in[1:0] == 2'b01 && y_zero) begin
              state    <= S_ERROR;
              err_code <= 2'b01;
            end else begin
              state    <= S_PROCESS;
              step_idx <= '0;
            end
          end
        end
        S_PROCESS: begin
          if (!bus.stall) begin
            if (step_idx == last_idx) begin
              state    <= S_DONE;
              step_idx <= '0;
            end else begin
              step_idx <= step_idx + 1'b1;
            end
          end else if (wd_trip) begin
            state    <= S_ERROR;
            err_code <= 2'b11;
            step_idx <= '0;
          end
        end
        S_DONE: begin
          if (bus.result_ack) begin
            state   <= S_IDLE;
            op_code <= 2'b00;
          end
        end
        S_ERROR: begin
          if (bus.result_ack) begin
            state    <= S_IDLE;
            err_code <= 2'b00;
            op_code  <= 2'b00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.dp_clear  = (state == S_SETUP);
  assign bus.load_x    = (state == S_LOADX) && bus.load;
  assign bus.load_y    = (state == S_LOADY) && bus.load;
  assign bus.load_op   = (state == S_LOADOP) && bus.load;
  assign bus.op_code   = op_code;
  assign bus.dp_step   = (state == S_PROCESS) && !bus.stall;
  assign bus.step_idx  = step_idx;
  assign bus.last_step = bus.dp_step && (step_idx == last_idx);
  assign bus.ready     = (state == S_DONE);
  assign bus.error     = (state == S_ERROR);
  assign bus.err_code  = err_code;
endmodule

// File: tb/tb_mdr_control_seq.sv
// tb/tb_mdr_control_seq.sv - directed vector bench for mdr_control_seq (DATA_W = 16)
module tb_mdr_control_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mdr_control_seq_if #(.DATA_W(16)) bus ();

  mdr_control_seq #(.DATA_W(16), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        load;
    logic [15:0] data;
    logic        stall;
    logic        abort;
    logic        ack;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // {busy, dp_clear, load_x, load_y, load_op, dp_step, last_step, ready, error, err_code, op_code, step_idx}
  function automatic logic [16:0] e(input logic busy, clr, lx, ly, lo, st, la, rd, er,
                                    input logic [1:0] ec, input logic [1:0] op,
                                    input logic [3:0] idx);
    return {busy, clr, lx, ly, lo, st, la, rd, er, ec, op, idx};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.busy, bus.dp_clear, bus.load_x, bus.load_y, bus.load_op, bus.dp_step,
            bus.last_step, bus.ready, bus.error, bus.err_code, bus.op_code, bus.step_idx};
  endfunction

  function automatic vec_t mkv(input string name, input logic s, l, input logic [15:0] d,
                               input logic st, ab, ak, input logic [16:0] ex);
    vec_t v;
    v.name = name; v.start = s; v.load = l; v.data = d;
    v.stall = st; v.abort = ab; v.ack = ak; v.exp = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs settle 1 time unit later.
  task automatic cyc(input logic s, l, input logic [15:0] d, input logic st, ab, ak);
    @(negedge clk);
    bus.start = s; bus.load = l; bus.data_in = d;
    bus.stall = st; bus.abort = ab; bus.result_ack = ak;
    #1;
  endtask

  task automatic begin_txn(input logic [15:0] x, y, input logic [1:0] op);
    cyc(1, 0, 16'h0, 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("setup_dp_clear", {bus.busy, bus.dp_clear}, 2'b11);
    cyc(0, 1, x, 0, 0, 0);
    chk("load_x", bus.load_x, 1);
    cyc(0, 1, y, 0, 0, 0);
    chk("load_y", bus.load_y, 1);
    cyc(0, 1, {14'h0, op}, 0, 0, 0);
    chk("load_op", bus.load_op, 1);
  endtask

  initial begin
    int steps;
    logic st;
    logic [3:0] exp_idx;
    checks = 0;
    errors = 0;
    bus.start = 0; bus.load = 0; bus.data_in = '0;
    bus.stall = 0; bus.abort = 0; bus.result_ack = 0;
    rst = 1;

    // Divide by zero, then invalid opcode; IDLE ignores load/stall/ack,
    // ERROR ignores start.
    vecs.push_back(mkv("idle_ignore", 0, 1, 16'h5, 1, 0, 1, e(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_start",    1, 0, 16'h0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_setup",    0, 0, 16'h0, 0, 0, 0, e(1,1,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_x_wait",   0, 0, 16'h0, 0, 0, 1, e(1,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_x",        0, 1, 16'h1234, 0, 0, 0, e(1,0,1,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_y",        0, 1, 16'h0, 0, 0, 0, e(1,0,0,1,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_op",       0, 1, 16'h1, 0, 0, 0, e(1,0,0,0,1,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("d0_err",      1, 0, 16'h0, 0, 0, 0, e(1,0,0,0,0,0,0,0,1,2'b01,2'b01,4'd0)));
    vecs.push_back(mkv("d0_err_ack",  0, 0, 16'h0, 0, 0, 1, e(1,0,0,0,0,0,0,0,1,2'b01,2'b01,4'd0)));
    vecs.push_back(mkv("d0_idle",     0, 0, 16'h0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("iv_start",    1, 0, 16'h0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("iv_setup",    0, 0, 16'h0, 0, 0, 0, e(1,1,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("iv_x",        0, 1, 16'h9, 0, 0, 0, e(1,0,1,0,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("iv_y",        0, 1, 16'h4, 0, 0, 0, e(1,0,0,1,0,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("iv_op",       0, 1, 16'hfff3, 0, 0, 0, e(1,0,0,0,1,0,0,0,0,2'b00,2'b00,4'd0)));
    vecs.push_back(mkv("iv_err",      1, 0, 16'h0, 0, 0, 0, e(1,0,0,0,0,0,0,0,1,2'b10,2'b11,4'd0)));
    vecs.push_back(mkv("iv_err_hold", 0, 0, 16'h0, 1, 0, 0, e(1,0,0,0,0,0,0,0,1,2'b10,2'b11,4'd0)));
    vecs.push_back(mkv("iv_err_ack",  0, 0, 16'h0, 0, 0, 1, e(1,0,0,0,0,0,0,0,1,2'b10,2'b11,4'd0)));
    vecs.push_back(mkv("iv_idle",     0, 0, 16'h0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0)));

    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_state", obs(), 17'h0);

    foreach (vecs[i]) begin
      cyc(vecs[i].start, vecs[i].load, vecs[i].data, vecs[i].stall, vecs[i].abort, vecs[i].ack);
      chk(vecs[i].name, obs(), vecs[i].exp);
    end

    // MUL: 16 unstalled steps, ready held five cycles until ack.
    begin_txn(16'h0003, 16'h0005, 2'b00);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 16'h0, 0, 0, 0);
      chk("mul_step", {bus.dp_step, bus.step_idx, bus.last_step}, {1'b1, 4'(i), (i == 15)});
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 16'h0, 0, 0, (k == 4));
      chk("mul_ready", {bus.busy, bus.ready, bus.dp_step, bus.step_idx}, {1'b1, 1'b1, 1'b0, 4'd0});
    end
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("mul_idle", obs(), 17'h0);

    // SQRT with a three-cycle stall at step 4 (Y = 0 is legal for SQRT).
    begin_txn(16'h0040, 16'h0000, 2'b10);
    steps = 0;
    for (int k = 0; k < 11; k++) begin
      st = (k >= 4 && k <= 6);
      exp_idx = (k < 4) ? 4'(k) : ((k <= 6) ? 4'd4 : 4'(k - 3));
      cyc(0, 0, 16'h0, st, 0, 0);
      if (bus.dp_step) steps++;
      chk("sqrt_step", {bus.dp_step, bus.step_idx, bus.last_step}, {!st, exp_idx, (k == 10)});
    end
    chk("sqrt_step_count", steps, 8);
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("sqrt_ready", {bus.ready, bus.op_code}, {1'b1, 2'b10});
    cyc(0, 0, 16'h0, 0, 0, 1);
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("sqrt_idle", obs(), 17'h0);

    // Abort at step 6.
    begin_txn(16'h0001, 16'h0001, 2'b00);
    for (int k = 0; k < 6; k++) cyc(0, 0, 16'h0, 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 1, 0);
    chk("abort_at_idx", bus.step_idx, 6);
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("abort_idle", obs(), 17'h0);

    // Reset while in LOADY; a load afterwards must not restart anything.
    cyc(1, 0, 16'h0, 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0, 0);
    cyc(0, 1, 16'h7, 0, 0, 0);
    cyc(0, 1, 16'h8, 0, 0, 0);
    chk("rst_in_loady", bus.load_y, 1);
    rst = 1;
    cyc(0, 0, 16'h0, 0, 0, 0);
    rst = 0;
    #1;
    chk("rst_outputs", obs(), 17'h0);
    cyc(0, 1, 16'h5, 0, 0, 0);
    chk("rst_needs_start", obs(), 17'h0);

    // Long stall in PROCESS.
    begin_txn(16'h0002, 16'h0003, 2'b01);
`ifdef MDR_WATCHDOG_EN
    for (int k = 0; k < 64; k++) begin
      cyc(0, 0, 16'h0, 1, 0, 0);
      chk("wd_stalling", {bus.busy, bus.error, bus.dp_step, bus.step_idx}, {3'b100, 4'd0});
    end
    cyc(0, 0, 16'h0, 1, 0, 0);
    chk("wd_timeout", {bus.error, bus.err_code, bus.ready}, {1'b1, 2'b11, 1'b0});
    cyc(0, 0, 16'h0, 0, 0, 1);
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("wd_idle", obs(), 17'h0);
`else
    for (int k = 0; k < 200; k++) begin
      cyc(0, 0, 16'h0, 1, 0, 0);
      chk("stall_wait", {bus.busy, bus.error, bus.ready, bus.dp_step, bus.step_idx}, {4'b1000, 4'd0});
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 16'h0, 0, 0, 0);
      chk("stall_resume", {bus.dp_step, bus.step_idx, bus.last_step}, {1'b1, 4'(i), (i == 15)});
    end
    cyc(0, 0, 16'h0, 0, 0, 1);
    chk("stall_ready", {bus.ready, bus.error, bus.err_code}, {2'b10, 2'b00});
    cyc(0, 0, 16'h0, 0, 0, 0);
    chk("stall_idle", obs(), 17'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdr_control_seq.md
Name: mdr_control_seq

Overview:
Parametrised control sequencer for the multiply/divide/square-root (MDR) unit.
- Accepts X, Y and opcode over a shared load bus.
- Validates operands before starting.
- Drives an iterative datapath with per-step strobes and a step index, honouring a datapath stall.
- Reports completion or a coded error, held until acknowledged.
- Sits between the top-level user interface and the MDR datapath registers.

Parameters:
- DATA_W, 16, operand width in bits; must be even and >= 4.
- TIMEOUT, 64, consecutive stall cycles tolerated in PROCESS (used only with the watchdog).
- CNT_W, $clog2(DATA_W), step index width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transaction; sampled only in IDLE
- load  in  1  capture strobe for data_in in the load states
- data_in  in  DATA_W  X, then Y, then opcode in bits [1:0]
- stall  in  1  datapath not ready for a step this cycle
- abort  in  1  cancel the current transaction
- result_ack  in  1  consumer acknowledges ready or error
- busy  out  1  high whenever the state is not IDLE
- dp_clear  out  1  one-cycle datapath clear, in SETUP
- load_x, load_y, load_op  out  1 each  high when (state matches) && load
- op_code  out  2  registered captured opcode
- dp_step  out  1  high in PROCESS && !stall
- step_idx  out  CNT_W  current iteration index, counting up from 0
- last_step  out  1  dp_step && step_idx == N-1
- ready  out  1  result valid; held until result_ack
- error  out  1  transaction failed; held until result_ack
- err_code  out  2  00 none, 01 divide by zero, 10 invalid opcode, 11 timeout

Behaviour:
- Reset and priority
  - rst is sampled on posedge clk. At the first edge with rst high: state = IDLE, step_idx = 0, op_code = 0, err_code = 0, internal y_zero = 0, stall counter = 0.
  - All outputs are 0 while state is IDLE and no load strobes are decoded.
  - Priority: rst > abort > normal transitions.
- Opcodes and iteration count N: 00 MUL, N = DATA_W; 01 DIV, N = DATA_W; 10 SQRT, N = DATA_W/2; 11 invalid.
- IDLE: start -> SETUP. load, stall and result_ack are ignored.
- SETUP: dp_clear = 1 for one cycle; unconditional -> LOADX.
- LOADX: load -> LOADY; otherwise stay.
- LOADY: load -> LOADOP, and y_zero <= (data_in == 0); otherwise stay.
- LOADOP: on load, op_code <= data_in[1:0], then:
  - opcode 11 -> ERROR, err_code = 10;
  - opcode 01 with y_zero -> ERROR, err_code = 01;
  - otherwise -> PROCESS with step_idx = 0.
  - No dp_step is ever issued on an error path.
- PROCESS:
  - Each cycle with !stall: dp_step = 1, then step_idx increments.
  - If the step has step_idx == N-1 (last_step): -> DONE and step_idx <= 0.
  - With stall = 1, step_idx holds and dp_step = 0.
  - Minimum PROCESS duration is N cycles.
- DONE: ready = 1 and held; result_ack -> IDLE.
- ERROR: error = 1 and err_code held; result_ack -> IDLE, err_code <= 00.
- start while busy is ignored and never queued.
- abort in any non-IDLE state -> IDLE next cycle. No ready or error is raised, and step_idx and err_code are cleared.
- result_ack outside DONE/ERROR is ignored.
- A load pulse spans exactly one state. A held load advances one state per cycle, by design.

Optional Feature:
MDR_WATCHDOG_EN:
- Defined: a stall counter counts consecutive PROCESS cycles with stall = 1 and clears on any non-stall cycle or on leaving PROCESS. When the count reaches TIMEOUT -> ERROR, err_code = 11.
- Undefined: no counter is built, PROCESS waits indefinitely under stall, and err_code 11 is never produced.

Test Plan (DATA_W = 16):
1. MUL: start; load X = 0x0003, Y = 0x0005, op = 00; stall = 0 -> dp_clear for 1 cycle after start; 16 consecutive dp_step with step_idx 0..15; last_step at 15; ready from the next cycle, held 5 cycles until result_ack, then IDLE with busy = 0.
2. DIV by zero: Y = 0x0000, op = 01 -> error = 1, err_code = 01 the cycle after the op load; zero dp_step; cleared one cycle after result_ack.
3. Invalid op: op = 11 -> err_code = 10, no dp_step. A start pulse while in ERROR is ignored.
4. SQRT with stall: op = 10; stall high for 3 cycles at step_idx = 4 -> step_idx holds at 4; 8 dp_step total across 11 PROCESS cycles; last_step at step_idx = 7.
5. Cancel and reset: abort at step_idx = 6 -> IDLE next cycle, busy = 0, ready = 0, error = 0. rst during LOADY -> all outputs 0 and a fresh start is required.
6. Watchdog: stall held for 64 cycles in PROCESS -> with MDR_WATCHDOG_EN, ERROR with err_code = 11 at cycle 64; without it, still in PROCESS at cycle 200 and completes after stall drops.
